// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
//   disp_arb_state_t : arbiter FSM state (IDLE / OWN)
//   DIGITS, NIBBLE_W : display geometry (4 digits of 4-bit nibbles)
//   VALUE_W          : width of one requester's display value
//   disp_value_t     : one requester's 16-bit display value
package disp_pkg;

    typedef enum logic {IDLE, OWN} disp_arb_state_t;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned VALUE_W  = DIGITS * NIBBLE_W;

    typedef logic [VALUE_W-1:0] disp_value_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker for the display arbiter.
// Default build: round-robin search starting at ptr_i+1 and wrapping modulo NREQ.
// With DISP_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and ptr_i is ignored.
// Ports:
//   req_i      : per-requester request vector
//   ptr_i      : round-robin pointer (last winner)
//   excl_en_i  : when high, requester excl_idx_i may not win
//   excl_idx_i : excluded requester index
//   valid_o    : a winner was found
//   idx_o      : winner index (0 when valid_o is low)
module rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             excl_en_i,
    input  logic [IDX_W-1:0] excl_idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

`ifdef DISP_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!valid_o && req_i[k] && !(excl_en_i && excl_idx_i == IDX_W'(k))) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end
`else
    // Candidate k sits at offset 'off' from the pointer when ptr == (k - off) mod NREQ.
    // Comparing ptr_i against that constant keeps every index static.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!valid_o && ptr_i == IDX_W'((k + NREQ - off) % NREQ) && req_i[k] &&
                    !(excl_en_i && excl_idx_i == IDX_W'(k))) begin
                    valid_o = 1'b1;
                    idx_o   = IDX_W'(k);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit seven-segment display between NREQ requesters.
// Round-robin arbitration with a minimum hold time per owner; the owner's
// 16-bit value is registered and split into four nibbles for the mux.
// Optional macro DISP_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins);
// requester 0 preempts any owner immediately, other owners honour the hold time.
// Ports:
//   clk_i            : system clock
//   rst_ni           : synchronous active-low reset
//   req_i[NREQ]      : level-sensitive display requests
//   data_i[16*NREQ]  : requester k value at bits [16k+15:16k]
//   gnt_o[NREQ]      : registered one-hot grant, zero when idle
//   owner_o          : current or last owner index
//   busy_o           : high while a grant is active
//   in0_o..in3_o     : registered nibbles, in0_o = value[3:0] (rightmost digit)
module display_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic [NREQ-1:0]                                 req_i,
    input  logic [16*NREQ-1:0]                              data_i,
    output logic [NREQ-1:0]                                 gnt_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]      owner_o,
    output logic                                            busy_o,
    output logic [3:0]                                      in0_o,
    output logic [3:0]                                      in1_o,
    output logic [3:0]                                      in2_o,
    output logic [3:0]                                      in3_o
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [HOLD_W-1:0] CNT_ONE  = 1;
    localparam logic [HOLD_W-1:0] CNT_DONE = HOLD_W'(HOLD_CYCLES);

    disp_arb_state_t   state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    disp_value_t       value_q, value_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_req;
    logic              hold_done;

    // While owning, the current owner is excluded so a switch always goes to someone else.
    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i      (req_i),
        .ptr_i      (ptr_q),
        .excl_en_i  (state_q == OWN),
        .excl_idx_i (owner_q),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    assign hold_done = (cnt_q == CNT_DONE);

    always_comb begin
        owner_req = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (owner_q == IDX_W'(k)) owner_req = req_i[k];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    // Pointer keeps the old owner so it becomes lowest priority.
                    state_d = IDLE;
`ifdef DISP_ARB_FIXED_PRIO_EN
                end else if (owner_q != '0 && req_i[0]) begin
                    owner_d = '0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else if (owner_q != '0 && hold_done && pick_valid) begin
`else
                end else if (hold_done && pick_valid) begin
`endif
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end else if (!hold_done) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant and display value follow the next owner; in IDLE the display freezes.
    always_comb begin
        gnt_d   = '0;
        value_d = value_q;
        if (state_d == OWN) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (owner_d == IDX_W'(k)) begin
                    gnt_d[k] = 1'b1;
                    value_d  = data_i[k*VALUE_W +: VALUE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            value_q <= value_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;
    assign busy_o  = (state_q == OWN);
    assign in0_o   = value_q[3:0];
    assign in1_o   = value_q[7:4];
    assign in2_o   = value_q[11:8];
    assign in3_o   = value_q[15:12];

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] d0, d1;
    logic [1:0]  gnt;
    logic        owner;
    logic        busy;
    logic [3:0]  in0, in1, in2, in3;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    typedef struct {
        string       tag;
        logic [1:0]  gnt;
        logic        owner;
        logic        busy;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    display_arbiter #(
        .NREQ        (2),
        .HOLD_CYCLES (8)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .data_i  ({d1, d0}),
        .gnt_o   (gnt),
        .owner_o (owner),
        .busy_o  (busy),
        .in0_o   (in0),
        .in1_o   (in1),
        .in2_o   (in2),
        .in3_o   (in3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant must never be multi-hot, and busy must track it.
    always @(negedge clk) begin
        if (armed) begin
            total++;
            assert ($onehot0(gnt) && (busy === (|gnt)))
            else begin
                bad++;
                $error("FAIL onehot observed gnt=%b busy=%b expected onehot0 with busy=|gnt",
                       gnt, busy);
            end
        end
    end

    task automatic push(input string tag, input logic [1:0] g, input logic o, input logic b,
                        input logic [15:0] v);
        exp_t e;
        e.tag   = tag;
        e.gnt   = g;
        e.owner = o;
        e.busy  = b;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic [15:0] val;
        @(posedge clk);
        #1;
        val = {in3, in2, in1, in0};
        total++;
        assert (sb.size() != 0)
        else begin
            bad++;
            $error("FAIL sb_empty observed=0 entries expected=1 entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (gnt === e.gnt)
            else begin
                bad++;
                $error("FAIL %s.gnt observed=%b expected=%b", e.tag, gnt, e.gnt);
            end
            total++;
            assert (owner === e.owner)
            else begin
                bad++;
                $error("FAIL %s.owner observed=%0d expected=%0d", e.tag, owner, e.owner);
            end
            total++;
            assert (busy === e.busy)
            else begin
                bad++;
                $error("FAIL %s.busy observed=%b expected=%b", e.tag, busy, e.busy);
            end
            total++;
            assert (val === e.val)
            else begin
                bad++;
                $error("FAIL %s.value observed=%h expected=%h", e.tag, val, e.val);
            end
        end
    endtask

    initial begin
        logic [1:0] g;
        rst_n = 1'b0;
        req   = 2'b11;
        d0    = 16'h5555;
        d1    = 16'h0042;

        // Reset held with both requesting: nothing granted, display cleared.
        repeat (3) begin
            push("rst", 2'b00, 1'b0, 1'b0, 16'h0000);
            tick();
            armed = 1'b1;
        end
        rst_n = 1'b1;
        push("rel", 2'b01, 1'b0, 1'b1, 16'h5555);
        tick();
        req = 2'b00;
        push("idle0", 2'b00, 1'b0, 1'b0, 16'h5555);
        tick();

        // Single requester with live data tracking, then frozen display.
        req = 2'b01;
        d0  = 16'h1234;
        push("t2gnt", 2'b01, 1'b0, 1'b1, 16'h1234);
        tick();
        total++;
        assert ({in3, in2, in1, in0} === {4'h1, 4'h2, 4'h3, 4'h4})
        else begin
            bad++;
            $error("FAIL t2nib observed=%h%h%h%h expected=1234", in3, in2, in1, in0);
        end
        d0 = 16'hABCD;
        push("t2trk", 2'b01, 1'b0, 1'b1, 16'hABCD);
        tick();
        req = 2'b00;
        push("t2drop", 2'b00, 1'b0, 1'b0, 16'hABCD);
        tick();
        total++;
        assert (in3 === 4'hA && in0 === 4'hD)
        else begin
            bad++;
            $error("FAIL t2frz observed in3=%h in0=%h expected in3=a in0=d", in3, in0);
        end

        // Hold then preempt: tenure covers counter 0..8, switch with no idle gap.
        req = 2'b01;
        d0  = 16'h1234;
        push("t3e0", 2'b01, 1'b0, 1'b1, 16'h1234);
        tick();
        push("t3e1", 2'b01, 1'b0, 1'b1, 16'h1234);
        tick();
        req = 2'b11;
        for (int k = 2; k <= 8; k++) begin
            push("t3hold", 2'b01, 1'b0, 1'b1, 16'h1234);
            tick();
        end
        push("t3sw", 2'b10, 1'b1, 1'b1, 16'h0042);
        tick();

        // Reset while requester 1 owns; first arbitration afterwards picks 0.
        rst_n = 1'b0;
        push("t5rst", 2'b00, 1'b0, 1'b0, 16'h0000);
        tick();
        rst_n = 1'b1;
        push("t5arb", 2'b01, 1'b0, 1'b1, 16'h1234);
        tick();

        // Fairness: both requesting, 9-cycle tenures alternating.
        for (int k = 1; k <= 40; k++) begin
            g = (((k / 9) % 2) == 0) ? 2'b01 : 2'b10;
            push("t4fair", g, g[1], 1'b1, g[1] ? 16'h0042 : 16'h1234);
            tick();
        end

        // Lone requester keeps the display well past the hold time.
        req = 2'b01;
        repeat (12) begin
            push("lone", 2'b01, 1'b0, 1'b1, 16'h1234);
            tick();
        end

        // Owner drops while the other requests: one idle cycle, then the other wins.
        req = 2'b10;
        push("drop", 2'b00, 1'b0, 1'b0, 16'h1234);
        tick();
        push("rearb", 2'b10, 1'b1, 1'b1, 16'h0042);
        tick();
        req = 2'b01;
        push("drop2", 2'b00, 1'b1, 1'b0, 16'h0042);
        tick();
        push("rearb2", 2'b01, 1'b0, 1'b1, 16'h1234);
        tick();

        total++;
        assert (sb.size() == 0)
        else begin
            bad++;
            $error("FAIL sb_left observed=%0d entries expected=0", sb.size());
        end

        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
